// File: rtl/q_serializer_if.sv
// q_serializer_if: request/result bundle for the charge-to-pulse transmitter.
// The master side drives start/q_in and observes the pulse train and results.
// The slave side is the serializer itself.
interface q_serializer_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 start;
  logic [BUS_WIDTH-1:0] q_in;
  logic                 q_serialized;
  logic                 busy;
  logic                 done;
  logic [BUS_WIDTH-1:0] residue;
  logic [BUS_WIDTH-1:0] pulse_count;

  modport master (
    output start,
    output q_in,
    input  q_serialized,
    input  busy,
    input  done,
    input  residue,
    input  pulse_count
  );

  modport slave (
    input  start,
    input  q_in,
    output q_serialized,
    output busy,
    output done,
    output residue,
    output pulse_count
  );
endinterface

// File: rtl/q_serializer.sv
// q_serializer: converts a parallel charge value into a burst of pulses, one
// pulse per Q_PER_PULSE charge units, each pulse HALF_PERIOD cycles high and
// HALF_PERIOD cycles low. Reports the pulse count and the unsent remainder.
//
// Optional feature macro: Q_SERIALIZER_ROUND_EN
//   defined   - one extra round pulse per request when the leftover charge is
//               at least half a pulse quantum (remainder itself is not reduced)
//   undefined - plain truncation, round_used stays 0
module q_serializer #(
  parameter int BUS_WIDTH   = 10,
  parameter int Q_PER_PULSE = 30,
  parameter int HALF_PERIOD = 3
) (
  input  logic          clk,
  input  logic          rst,
  q_serializer_if.slave bus
);

  localparam int CNT_W = $clog2(HALF_PERIOD + 1);
  localparam logic [BUS_WIDTH-1:0] Q          = BUS_WIDTH'(Q_PER_PULSE);
  localparam logic [CNT_W-1:0]     PHASE_LAST = CNT_W'(HALF_PERIOD - 1);

`ifdef Q_SERIALIZER_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state, state_d;
  logic [BUS_WIDTH-1:0] rem, rem_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic                 round_used, round_used_d;
  logic                 q_ser, q_ser_d;
  logic                 busy_r, busy_d;
  logic                 done_r, done_d;
  logic [BUS_WIDTH-1:0] residue_r, residue_d;
  logic [BUS_WIDTH-1:0] pulse_count_r, pulse_count_d;

  // A round pulse is due when the leftover is below one quantum but at least
  // half of one, and no round pulse has been spent on this request yet.
  function automatic logic round_due(input logic [BUS_WIDTH-1:0] value,
                                     input logic                 used);
    return ROUND_EN && !used && (value < Q) &&
           ({value, 1'b0} >= {1'b0, Q});
  endfunction

  // Next-state and next-output decisions for the pulse sequencer.
  always_comb begin
    state_d       = state;
    rem_d         = rem;
    cnt_d         = cnt;
    round_used_d  = round_used;
    q_ser_d       = q_ser;
    busy_d        = busy_r;
    done_d        = 1'b0;
    residue_d     = residue_r;
    pulse_count_d = pulse_count_r;

    case (state)
      IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.q_in >= Q) begin
            state_d       = HIGH;
            rem_d         = bus.q_in - Q;
            pulse_count_d = BUS_WIDTH'(1);
            q_ser_d       = 1'b1;
            cnt_d         = PHASE_LAST;
            round_used_d  = 1'b0;
          end else if (round_due(bus.q_in, 1'b0)) begin
            state_d       = HIGH;
            rem_d         = bus.q_in;
            pulse_count_d = BUS_WIDTH'(1);
            q_ser_d       = 1'b1;
            cnt_d         = PHASE_LAST;
            round_used_d  = 1'b1;
          end else begin
            state_d       = DONE;
            rem_d         = bus.q_in;
            pulse_count_d = '0;
            round_used_d  = 1'b0;
            done_d        = 1'b1;
            residue_d     = bus.q_in;
          end
        end
      end

      HIGH: begin
        if (cnt == '0) begin
          state_d = LOW;
          q_ser_d = 1'b0;
          cnt_d   = PHASE_LAST;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      LOW: begin
        if (cnt == '0) begin
          if (rem >= Q) begin
            state_d       = HIGH;
            rem_d         = rem - Q;
            pulse_count_d = pulse_count_r + BUS_WIDTH'(1);
            q_ser_d       = 1'b1;
            cnt_d         = PHASE_LAST;
          end else if (round_due(rem, round_used)) begin
            state_d       = HIGH;
            pulse_count_d = pulse_count_r + BUS_WIDTH'(1);
            q_ser_d       = 1'b1;
            cnt_d         = PHASE_LAST;
            round_used_d  = 1'b1;
          end else begin
            state_d   = DONE;
            done_d    = 1'b1;
            residue_d = rem;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        q_ser_d = 1'b0;
      end
    endcase

    if (!ROUND_EN) begin
      round_used_d = 1'b0;
    end
  end

  // State and result registers; reset may land mid-pulse and clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rem           <= '0;
      cnt           <= '0;
      round_used    <= 1'b0;
      q_ser         <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      residue_r     <= '0;
      pulse_count_r <= '0;
    end else begin
      state         <= state_d;
      rem           <= rem_d;
      cnt           <= cnt_d;
      round_used    <= round_used_d;
      q_ser         <= q_ser_d;
      busy_r        <= busy_d;
      done_r        <= done_d;
      residue_r     <= residue_d;
      pulse_count_r <= pulse_count_d;
    end
  end

  assign bus.q_serialized = q_ser;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.residue      = residue_r;
  assign bus.pulse_count  = pulse_count_r;

endmodule
